// File: rtl/sterowanie_pobierania_if.sv
// rtl/sterowanie_pobierania_if.sv - decoder-side instruction handshake and redirect bundle
interface sterowanie_pobierania_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  logic                  jump_en;
  logic [ADDR_WIDTH-1:0] jump_addr;
  logic                  branch_en;
  logic [ADDR_WIDTH-1:0] branch_off;
  logic                  call_en;
  logic                  ret_en;

  modport master (
    output instr, instr_pc, instr_valid,
    input  instr_ready, jump_en, jump_addr, branch_en, branch_off, call_en, ret_en
  );

  modport slave (
    input  instr, instr_pc, instr_valid,
    output instr_ready, jump_en, jump_addr, branch_en, branch_off, call_en, ret_en
  );
endinterface

// File: rtl/sterowanie_pobierania.sv
// rtl/sterowanie_pobierania.sv - instruction fetch controller with redirects and return stack
module sterowanie_pobierania #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  sterowanie_pobierania_if.master dec,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  halt,
  output logic                  halted,
  output logic                  stack_err
);
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [1:0] {S_RUN, S_HALT, S_ERROR} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic                  valid_q, valid_d;
  logic [SP_W-1:0]       sp_q, sp_d;
  logic [ADDR_WIDTH-1:0] stack [2**IDX_W];
  logic                  push;
  logic [ADDR_WIDTH-1:0] push_data;
  logic [IDX_W-1:0]      rd_idx, wr_idx;
  logic                  consume;

  assign rd_idx  = IDX_W'(sp_q - SP_W'(1));
  assign wr_idx  = IDX_W'(sp_q);
  assign consume = valid_q && dec.instr_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    sp_d       = sp_q;
    push       = 1'b0;
    push_data  = instr_pc_q + ADDR_WIDTH'(1);
    case (state_q)
      S_RUN: begin
        // Any redirect implies the decoder took the current word, so it flushes without instr_ready.
        if (dec.ret_en) begin
          valid_d = 1'b0;
          if (sp_q == '0) begin
            state_d = S_ERROR;
          end else begin
            pc_d = stack[rd_idx];
            sp_d = sp_q - SP_W'(1);
          end
        end else if (dec.call_en) begin
          valid_d = 1'b0;
          if (sp_q == SP_W'(STACK_DEPTH)) begin
            state_d = S_ERROR;
          end else begin
            push = 1'b1;
            sp_d = sp_q + SP_W'(1);
            pc_d = dec.jump_addr;
          end
        end else if (dec.jump_en) begin
          valid_d = 1'b0;
          pc_d    = dec.jump_addr;
        end else if (dec.branch_en) begin
          valid_d = 1'b0;
          pc_d    = instr_pc_q + dec.branch_off;
        end else if (halt) begin
          if (consume) valid_d = 1'b0;
        end else if (!valid_q || dec.instr_ready) begin
          instr_d    = rom_data;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          pc_d       = pc_q + ADDR_WIDTH'(1);
        end
        if (halt && state_d != S_ERROR) state_d = S_HALT;
      end
      S_HALT: begin
        if (consume) valid_d = 1'b0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      pc_q       <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      sp_q       <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      sp_q       <= sp_d;
    end
  end

  // Stack contents are don't-care after reset; only sp is cleared.
  always_ff @(posedge clk) begin
    if (push) stack[wr_idx] <= push_data;
  end

  assign rom_addr        = pc_q;
  assign dec.instr       = instr_q;
  assign dec.instr_pc    = instr_pc_q;
  assign dec.instr_valid = valid_q;
  assign halted          = (state_q == S_HALT);
  assign stack_err       = (state_q == S_ERROR);
endmodule

// File: tb/tb_sterowanie_pobierania.sv
// tb/tb_sterowanie_pobierania.sv - directed bench for the fetch controller
module tb_sterowanie_pobierania;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        halt;
  logic        halted;
  logic        stack_err;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  sterowanie_pobierania_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

  sterowanie_pobierania #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .STACK_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .dec       (bus),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .halt      (halt),
    .halted    (halted),
    .stack_err (stack_err)
  );

  function automatic logic [15:0] romval(input logic [7:0] a);
    return {a ^ 8'h5A, a};
  endfunction

  assign rom_data = romval(rom_addr);

  task automatic idle_inputs();
    bus.jump_en    = 1'b0;
    bus.jump_addr  = 8'h00;
    bus.branch_en  = 1'b0;
    bus.branch_off = 8'h00;
    bus.call_en    = 1'b0;
    bus.ret_en     = 1'b0;
    halt           = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    bus.instr_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic goto_addr(input logic [7:0] a);
    bus.jump_en   = 1'b1;
    bus.jump_addr = a;
    @(negedge clk);
    bus.jump_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.instr_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({bus.instr_valid, bus.instr, bus.instr_pc, rom_addr} !== 33'd0) begin
      bad++;
      $display("FAIL reset_regs got=%h exp=0", {bus.instr_valid, bus.instr, bus.instr_pc, rom_addr});
    end
    total++;
    if ({halted, stack_err} !== 2'b00) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=00", {halted, stack_err});
    end
    bus.instr_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.instr_valid, rom_addr} !== 9'd0) begin
      bad++;
      $display("FAIL reset_hold got=%h exp=0", {bus.instr_valid, rom_addr});
    end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    apply_reset();
    bus.instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 8'(k), romval(8'(k))}) begin
        bad++;
        $display("FAIL seq_%0d got=%h exp=%h", k, {bus.instr_valid, bus.instr_pc, bus.instr},
                 {1'b1, 8'(k), romval(8'(k))});
      end
    end
    total++;
    if (rom_addr !== 8'h04) begin
      bad++;
      $display("FAIL seq_pc got=%h exp=04", rom_addr);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    bus.instr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if ({bus.instr_valid, bus.instr_pc, bus.instr, rom_addr} !== {1'b1, 8'h01, romval(8'h01), 8'h02}) begin
        bad++;
        $display("FAIL stall_hold_%0d got=%h exp=%h", k, {bus.instr_valid, bus.instr_pc, bus.instr, rom_addr},
                 {1'b1, 8'h01, romval(8'h01), 8'h02});
      end
    end
    bus.instr_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 8'h02, romval(8'h02)}) begin
      bad++;
      $display("FAIL stall_resume got=%h exp=%h", {bus.instr_valid, bus.instr_pc, bus.instr},
               {1'b1, 8'h02, romval(8'h02)});
    end
  endtask

  task automatic test_jump();
    apply_reset();
    bus.instr_ready = 1'b1;
    repeat (6) @(negedge clk);
    total++;
    if (bus.instr_pc !== 8'h05) begin
      bad++;
      $display("FAIL jump_pre got=%h exp=05", bus.instr_pc);
    end
    bus.jump_en   = 1'b1;
    bus.jump_addr = 8'h40;
    @(negedge clk);
    bus.jump_en = 1'b0;
    total++;
    if ({bus.instr_valid, rom_addr} !== {1'b0, 8'h40}) begin
      bad++;
      $display("FAIL jump_flush got=%h exp=040", {bus.instr_valid, rom_addr});
    end
    @(negedge clk);
    total++;
    if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 8'h40, romval(8'h40)}) begin
      bad++;
      $display("FAIL jump_fetch got=%h exp=%h", {bus.instr_valid, bus.instr_pc, bus.instr},
               {1'b1, 8'h40, romval(8'h40)});
    end
  endtask

  task automatic test_branch();
    goto_addr(8'h10);
    bus.branch_en  = 1'b1;
    bus.branch_off = 8'hFC;
    @(negedge clk);
    bus.branch_en = 1'b0;
    total++;
    if ({bus.instr_valid, rom_addr} !== {1'b0, 8'h0C}) begin
      bad++;
      $display("FAIL branch_back got=%h exp=00c", {bus.instr_valid, rom_addr});
    end
    @(negedge clk);
    total++;
    if (bus.instr_pc !== 8'h0C) begin
      bad++;
      $display("FAIL branch_back_fetch got=%h exp=0c", bus.instr_pc);
    end
    goto_addr(8'hFE);
    bus.branch_en  = 1'b1;
    bus.branch_off = 8'h03;
    @(negedge clk);
    bus.branch_en = 1'b0;
    total++;
    if (rom_addr !== 8'h01) begin
      bad++;
      $display("FAIL branch_wrap got=%h exp=01", rom_addr);
    end
    goto_addr(8'hFE);
    @(negedge clk);
    total++;
    if (bus.instr_pc !== 8'hFF) begin
      bad++;
      $display("FAIL pc_ff got=%h exp=ff", bus.instr_pc);
    end
    @(negedge clk);
    total++;
    if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 8'h00, romval(8'h00)}) begin
      bad++;
      $display("FAIL pc_wrap got=%h exp=%h", {bus.instr_valid, bus.instr_pc, bus.instr},
               {1'b1, 8'h00, romval(8'h00)});
    end
    bus.jump_en    = 1'b1;
    bus.jump_addr  = 8'h70;
    bus.branch_en  = 1'b1;
    bus.branch_off = 8'h08;
    @(negedge clk);
    idle_inputs();
    total++;
    if (rom_addr !== 8'h70) begin
      bad++;
      $display("FAIL prio_jump_branch got=%h exp=70", rom_addr);
    end
  endtask

  task automatic test_call_ret();
    apply_reset();
    bus.instr_ready = 1'b1;
    goto_addr(8'h20);
    bus.call_en   = 1'b1;
    bus.jump_addr = 8'h80;
    @(negedge clk);
    bus.call_en = 1'b0;
    total++;
    if ({bus.instr_valid, rom_addr, stack_err} !== {1'b0, 8'h80, 1'b0}) begin
      bad++;
      $display("FAIL call_target got=%h exp=100", {bus.instr_valid, rom_addr, stack_err});
    end
    repeat (3) @(negedge clk);
    total++;
    if (bus.instr_pc !== 8'h82) begin
      bad++;
      $display("FAIL call_body got=%h exp=82", bus.instr_pc);
    end
    bus.ret_en = 1'b1;
    @(negedge clk);
    bus.ret_en = 1'b0;
    total++;
    if ({bus.instr_valid, rom_addr} !== {1'b0, 8'h21}) begin
      bad++;
      $display("FAIL ret_target got=%h exp=021", {bus.instr_valid, rom_addr});
    end
    @(negedge clk);
    total++;
    if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 8'h21, romval(8'h21)}) begin
      bad++;
      $display("FAIL ret_fetch got=%h exp=%h", {bus.instr_valid, bus.instr_pc, bus.instr},
               {1'b1, 8'h21, romval(8'h21)});
    end
  endtask

  task automatic test_back_to_back_overflow();
    apply_reset();
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.call_en   = 1'b1;
      bus.jump_addr = 8'(8'h30 + i * 16);
      @(negedge clk);
      if (i == 3) begin
        total++;
        if ({stack_err, rom_addr} !== {1'b0, 8'h60}) begin
          bad++;
          $display("FAIL call4 got=%h exp=060", {stack_err, rom_addr});
        end
      end
    end
    bus.call_en = 1'b0;
    total++;
    if ({stack_err, bus.instr_valid, rom_addr, halted} !== {1'b1, 1'b0, 8'h60, 1'b0}) begin
      bad++;
      $display("FAIL overflow got=%h exp=%h", {stack_err, bus.instr_valid, rom_addr, halted},
               {1'b1, 1'b0, 8'h60, 1'b0});
    end
    bus.jump_en   = 1'b1;
    bus.jump_addr = 8'h11;
    @(negedge clk);
    bus.jump_en = 1'b0;
    total++;
    if ({stack_err, bus.instr_valid, rom_addr} !== {1'b1, 1'b0, 8'h60}) begin
      bad++;
      $display("FAIL error_frozen got=%h exp=260", {stack_err, bus.instr_valid, rom_addr});
    end
  endtask

  task automatic test_underflow();
    apply_reset();
    bus.instr_ready = 1'b1;
    bus.ret_en      = 1'b1;
    @(negedge clk);
    bus.ret_en = 1'b0;
    total++;
    if ({stack_err, bus.instr_valid, rom_addr} !== {1'b1, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL underflow got=%h exp=200", {stack_err, bus.instr_valid, rom_addr});
    end
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    total++;
    if ({halted, stack_err} !== 2'b01) begin
      bad++;
      $display("FAIL error_halt got=%b exp=01", {halted, stack_err});
    end
  endtask

  task automatic test_halt();
    apply_reset();
    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    total++;
    if ({halted, bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 1'b1, 8'h00, romval(8'h00)}) begin
      bad++;
      $display("FAIL halt_hold got=%h exp=%h", {halted, bus.instr_valid, bus.instr_pc, bus.instr},
               {1'b1, 1'b1, 8'h00, romval(8'h00)});
    end
    @(negedge clk);
    total++;
    if ({halted, bus.instr_valid, rom_addr} !== {1'b1, 1'b1, 8'h01}) begin
      bad++;
      $display("FAIL halt_hold2 got=%h exp=301", {halted, bus.instr_valid, rom_addr});
    end
    bus.instr_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({halted, bus.instr_valid} !== 2'b10) begin
      bad++;
      $display("FAIL halt_drain got=%b exp=10", {halted, bus.instr_valid});
    end
    bus.jump_en   = 1'b1;
    bus.jump_addr = 8'h33;
    @(negedge clk);
    bus.jump_en = 1'b0;
    total++;
    if ({bus.instr_valid, rom_addr} !== {1'b0, 8'h01}) begin
      bad++;
      $display("FAIL halt_nofetch got=%h exp=001", {bus.instr_valid, rom_addr});
    end
    bus.instr_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({halted, stack_err, bus.instr_valid, bus.instr, bus.instr_pc, rom_addr} !== 35'd0) begin
      bad++;
      $display("FAIL halt_reset got=%h exp=0",
               {halted, stack_err, bus.instr_valid, bus.instr, bus.instr_pc, rom_addr});
    end
  endtask

  task automatic test_halt_redirect();
    apply_reset();
    bus.instr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    halt          = 1'b1;
    bus.jump_en   = 1'b1;
    bus.jump_addr = 8'h55;
    @(negedge clk);
    idle_inputs();
    total++;
    if ({halted, bus.instr_valid, rom_addr} !== {1'b1, 1'b0, 8'h55}) begin
      bad++;
      $display("FAIL halt_jump got=%h exp=255", {halted, bus.instr_valid, rom_addr});
    end
    @(negedge clk);
    total++;
    if ({bus.instr_valid, rom_addr} !== {1'b0, 8'h55}) begin
      bad++;
      $display("FAIL halt_jump_idle got=%h exp=055", {bus.instr_valid, rom_addr});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.instr_ready = 1'b0;
    idle_inputs();
    test_reset();
    test_sequential();
    test_stall();
    test_jump();
    test_branch();
    test_call_ret();
    test_back_to_back_overflow();
    test_underflow();
    test_halt();
    test_halt_redirect();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
